// File: rtl/gpio_in_conditioner.sv
// Pad input conditioner: per-bit synchronizer, saturating debounce, edge pulses.
// Define GPIO_EVENT_LATCH_EN to build the sticky event flags and the irq output.
module gpio_in_conditioner #(
    parameter int NB_BITS     = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NB_BITS-1:0]   pad_gpio_i,
    input  logic [DEB_WIDTH-1:0] deb_len_i,
    input  logic                 bypass_i,
    input  logic [NB_BITS-1:0]   evt_clr_i,
    output logic [NB_BITS-1:0]   gpio_o,
    output logic [NB_BITS-1:0]   rise_o,
    output logic [NB_BITS-1:0]   fall_o,
    output logic [NB_BITS-1:0]   evt_o,
    output logic                 irq_o
);

    localparam logic [DEB_WIDTH-1:0] CNT_ONE = DEB_WIDTH'(1);

    logic [SYNC_STAGES-1:0][NB_BITS-1:0] sync_q;
    logic [NB_BITS-1:0]                  sync;
    logic [NB_BITS-1:0][DEB_WIDTH-1:0]   cnt_q;
    logic [NB_BITS-1:0][DEB_WIDTH-1:0]   cnt_d;
    logic [NB_BITS-1:0]                  gpio_q;
    logic [NB_BITS-1:0]                  gpio_d;
    logic [NB_BITS-1:0]                  rise_q;
    logic [NB_BITS-1:0]                  fall_q;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_gpio_i};
        end
    end

    // The >= test lets a count already past a freshly lowered threshold accept at once.
    always_comb begin
        gpio_d = gpio_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < NB_BITS; i++) begin
            if (bypass_i) begin
                gpio_d[i] = sync[i];
                cnt_d[i]  = '0;
            end else if (sync[i] == gpio_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= deb_len_i) begin
                gpio_d[i] = sync[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            gpio_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            gpio_q <= gpio_d;
            rise_q <= gpio_d & ~gpio_q;
            fall_q <= ~gpio_d & gpio_q;
        end
    end

    assign gpio_o = gpio_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef GPIO_EVENT_LATCH_EN
    logic [NB_BITS-1:0] evt_q;

    // Flags set on the edge that raises a pulse; OR-ing last makes set beat clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= (evt_q & ~evt_clr_i) | (gpio_d ^ gpio_q);
        end
    end

    assign evt_o = evt_q;
    assign irq_o = |evt_q;
`else
    logic unused_evt_clr;

    assign unused_evt_clr = ^evt_clr_i;
    assign evt_o          = '0;
    assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Randomized and directed bench for gpio_in_conditioner against a cycle-level reference model.
// Honours GPIO_EVENT_LATCH_EN the same way as the design.
module tb_gpio_in_conditioner;

    localparam int NB = 16;
    localparam int S  = 2;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [NB-1:0] pad;
    logic [DW-1:0] deb;
    logic          byp;
    logic [NB-1:0] clr;
    logic [NB-1:0] gpio;
    logic [NB-1:0] rise;
    logic [NB-1:0] fall;
    logic [NB-1:0] evt;
    logic          irq;

    int total = 0;
    int bad   = 0;

    gpio_in_conditioner #(.NB_BITS(NB), .SYNC_STAGES(S), .DEB_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pad_gpio_i (pad),
        .deb_len_i  (deb),
        .bypass_i   (byp),
        .evt_clr_i  (clr),
        .gpio_o     (gpio),
        .rise_o     (rise),
        .fall_o     (fall),
        .evt_o      (evt),
        .irq_o      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: pad history queue stands in for the synchronizer delay,
    // and each bit keeps the length of its current run of disagreement.
    logic [NB-1:0] m_hist[$];
    logic [NB-1:0] m_level;
    logic [NB-1:0] m_rise;
    logic [NB-1:0] m_fall;
    logic [NB-1:0] m_evt;
    int            m_run[NB];

    always @(posedge clk) begin
        logic [NB-1:0] seen;
        logic [NB-1:0] nxt;
        if (rst) begin
            m_hist.delete();
            for (int k = 0; k < S; k++) m_hist.push_back('0);
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_evt   = '0;
            for (int k = 0; k < NB; k++) m_run[k] = 0;
        end else begin
            seen = m_hist[S-1];
            nxt  = m_level;
            for (int k = 0; k < NB; k++) begin
                if (byp) begin
                    nxt[k]   = seen[k];
                    m_run[k] = 0;
                end else if (seen[k] != m_level[k]) begin
                    if (m_run[k] >= int'(deb)) begin
                        nxt[k]   = seen[k];
                        m_run[k] = 0;
                    end else begin
                        m_run[k] = m_run[k] + 1;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_rise = nxt & ~m_level;
            m_fall = m_level & ~nxt;
`ifdef GPIO_EVENT_LATCH_EN
            m_evt  = (m_evt & ~clr) | m_rise | m_fall;
`else
            m_evt  = '0;
`endif
            m_level = nxt;
            m_hist.push_front(pad);
            m_hist = m_hist[0:S-1];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compareModel();
        checkOutput("gpio", 32'(gpio), 32'(m_level));
        checkOutput("rise", 32'(rise), 32'(m_rise));
        checkOutput("fall", 32'(fall), 32'(m_fall));
        checkOutput("evt", 32'(evt), 32'(m_evt));
        checkOutput("irq", 32'(irq), 32'(|m_evt));
        checkOutput("excl", 32'(rise & fall), 32'h0);
    endtask

    // Drive one cycle of inputs, let one edge pass, sample on the falling edge.
    task automatic applyStimulus(input logic [NB-1:0] p, input logic [DW-1:0] d,
                                 input logic b, input logic [NB-1:0] c, input logic r);
        pad = p;
        deb = d;
        byp = b;
        clr = c;
        rst = r;
        @(posedge clk);
        @(negedge clk);
        compareModel();
    endtask

    task automatic resetDut(input logic [DW-1:0] d);
        applyStimulus('0, d, 1'b0, '0, 1'b1);
        checkOutput("rst_gpio", 32'(gpio), 32'h0);
        checkOutput("rst_pulse", 32'(rise | fall), 32'h0);
        checkOutput("rst_evt", 32'(evt), 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
    endtask

    initial begin
        int            lat;
        int            nrise;
        int            nfall;
        logic          flag;
        logic [NB-1:0] rh[1:20];
        logic [NB-1:0] r_pad;
        logic [DW-1:0] r_deb;
        logic          r_byp;
        logic [NB-1:0] r_clr;
        logic          r_rst;

        pad = '0; deb = '0; byp = 1'b0; clr = '0; rst = 1'b1;

        // Debounce latency on bit 3 with threshold 4.
        resetDut(8'd4);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            applyStimulus(16'h0008, 8'd4, 1'b0, '0, 1'b0);
            rh[n] = rise;
            if (gpio[3] && lat == 0) lat = n;
        end
        checkOutput("lat_deb4", 32'(lat), 32'd7);
        checkOutput("rise_b3", 32'(rh[7]), 32'h0008);
        checkOutput("rise_b3_end", 32'(rh[8]), 32'h0);
        checkOutput("quiet_bits", 32'(gpio), 32'h0008);

        // Glitch of 3 cycles rejected, 5 cycles accepted.
        resetDut(8'd4);
        flag = 1'b0;
        for (int n = 0; n < 15; n++) begin
            applyStimulus((n < 3) ? 16'h0001 : 16'h0000, 8'd4, 1'b0, '0, 1'b0);
            if (gpio[0] || rise[0] || fall[0]) flag = 1'b1;
        end
        checkOutput("glitch3", 32'(flag), 32'h0);
        flag = 1'b0;
        for (int n = 0; n < 15; n++) begin
            applyStimulus((n < 5) ? 16'h0001 : 16'h0000, 8'd4, 1'b0, '0, 1'b0);
            if (gpio[0]) flag = 1'b1;
        end
        checkOutput("glitch5", 32'(flag), 32'h1);

        // Bypass: toggle every 4 cycles.
        resetDut(8'd4);
        lat = 0; nrise = 0; nfall = 0;
        for (int n = 1; n <= 24; n++) begin
            applyStimulus((((n - 1) / 4) % 2 == 0) ? 16'hFFFF : 16'h0000, 8'd4, 1'b1, '0, 1'b0);
            if (gpio == 16'hFFFF && lat == 0) lat = n;
            if (rise != 0) nrise++;
            if (fall != 0) nfall++;
        end
        checkOutput("lat_byp", 32'(lat), 32'd3);
        checkOutput("byp_rises", 32'(nrise), 32'd3);
        checkOutput("byp_falls", 32'(nfall), 32'd3);

        // Lowering the threshold below an in-flight count accepts on the next edge.
        resetDut(8'd200);
        for (int n = 1; n <= 52; n++) applyStimulus(16'h0002, 8'd200, 1'b0, '0, 1'b0);
        checkOutput("thr_hold", 32'(gpio[1]), 32'h0);
        applyStimulus(16'h0002, 8'd10, 1'b0, '0, 1'b0);
        checkOutput("thr_accept", 32'(gpio[1]), 32'h1);
        checkOutput("thr_rise", 32'(rise), 32'h0002);

        // Reset in the middle of a debounce on bit 5.
        resetDut(8'd4);
        for (int n = 1; n <= 5; n++) applyStimulus(16'h0020, 8'd4, 1'b0, '0, 1'b0);
        applyStimulus(16'h0020, 8'd4, 1'b0, '0, 1'b1);
        checkOutput("mid_rst_gpio", 32'(gpio | rise | fall | evt), 32'h0);
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            applyStimulus(16'h0020, 8'd4, 1'b0, '0, 1'b0);
            if (gpio[5] && lat == 0) lat = n;
        end
        checkOutput("lat_after_rst", 32'(lat), 32'd7);

        // Sticky events on bit 7.
        resetDut(8'd0);
        for (int n = 0; n < 4; n++) applyStimulus(16'h0080, 8'd0, 1'b0, '0, 1'b0);
        applyStimulus(16'h0080, 8'd0, 1'b0, 16'h0080, 1'b0);
        for (int n = 0; n < 3; n++) applyStimulus(16'h0000, 8'd0, 1'b0, '0, 1'b0);
`ifdef GPIO_EVENT_LATCH_EN
        checkOutput("evt_fall", 32'(evt), 32'h0080);
        checkOutput("irq_fall", 32'(irq), 32'h1);
`else
        checkOutput("evt_off", 32'(evt), 32'h0);
        checkOutput("irq_off", 32'(irq), 32'h0);
`endif
        applyStimulus(16'h0080, 8'd0, 1'b0, '0, 1'b0);
        applyStimulus(16'h0080, 8'd0, 1'b0, '0, 1'b0);
        applyStimulus(16'h0080, 8'd0, 1'b0, 16'h0080, 1'b0);
        checkOutput("set_vs_clr_rise", 32'(rise), 32'h0080);
`ifdef GPIO_EVENT_LATCH_EN
        checkOutput("set_wins", 32'(evt), 32'h0080);
`endif
        applyStimulus(16'h0080, 8'd0, 1'b0, 16'h0080, 1'b0);
        checkOutput("clr_alone_evt", 32'(evt), 32'h0);
        checkOutput("clr_alone_irq", 32'(irq), 32'h0);

        // Randomized traffic against the model.
        resetDut(8'd3);
        r_pad = '0; r_deb = 8'd3; r_byp = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) r_deb = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0)
                r_pad = r_pad ^ (NB'($urandom) & NB'($urandom) & NB'($urandom));
            if ($urandom_range(0, 59) == 0) r_byp = ~r_byp;
            r_clr = NB'($urandom) & NB'($urandom);
            r_rst = ($urandom_range(0, 249) == 0);
            applyStimulus(r_pad, r_deb, r_byp, r_clr, r_rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
